// File: rtl/adpcm_sched_pkg.sv
// ============================================================================
// adpcm_sched_pkg : shared encodings for the adpcm codec-core scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef GRAY
`define GRAY(n) ((n) ^ ((n) >> 1))
`endif

package adpcm_sched_pkg;

  localparam int c_PCM_W = 16;
  localparam int c_NIB_W = 4;

  localparam logic c_SEL_ENC = 1'b0;
  localparam logic c_SEL_DEC = 1'b1;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t c_IDLE    = 2'(`GRAY(0));
  localparam sched_state_t c_SETUP   = 2'(`GRAY(1));
  localparam sched_state_t c_WAIT_LO = 2'(`GRAY(2));
  localparam sched_state_t c_WAIT_HI = 2'(`GRAY(3));

  function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] lim);
    return (v >= lim) ? lim : v + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adpcm_sched_arb.sv
// ============================================================================
// adpcm_sched_arb : encode/decode grant logic with bounded decode burst
// Revision: 1.0
// ============================================================================
`default_nettype none

module adpcm_sched_arb
  import adpcm_sched_pkg::*;
#(
  parameter int DEC_BURST = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic enc_valid,
  input  logic dec_valid,
  input  logic accept,
  output logic grant_dec,
  output logic grant_valid
);

  localparam logic [2:0] c_BURST = 3'(DEC_BURST);

  logic [2:0] r_dec_run;

  // decode wins a tie only while it has burst credit left
  always_comb begin
    grant_valid = enc_valid | dec_valid;
    grant_dec   = dec_valid & (~enc_valid | (r_dec_run < c_BURST));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dec_run <= '0;
    end else if (!enable) begin
      r_dec_run <= '0;
    end else if (accept) begin
      r_dec_run <= grant_dec ? sat_inc3(r_dec_run, c_BURST) : 3'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adpcm_sched.sv
// ============================================================================
// adpcm_sched : shares one adpcm codec core between encode and decode users
// Optional job timeout: define ADPCM_SCHED_TIMEOUT_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module adpcm_sched
  import adpcm_sched_pkg::*;
#(
  parameter int DEC_BURST = 1,
  parameter int TIMEOUT   = 31
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               enc_valid,
  input  logic [c_PCM_W-1:0] enc_pcm,
  output logic               enc_ready,
  output logic               enc_done,
  output logic [c_NIB_W-1:0] enc_adpcm,
  input  logic               dec_valid,
  input  logic [c_NIB_W-1:0] dec_adpcm,
  output logic               dec_ready,
  output logic               dec_done,
  output logic [c_PCM_W-1:0] dec_pcm,
  output logic               core_req,
  output logic               core_sel_rx,
  output logic [c_PCM_W-1:0] core_rx_pcm,
  output logic [c_NIB_W-1:0] core_rx_adpcm,
  input  logic               core_ack,
  input  logic [c_PCM_W-1:0] core_tx_pcm,
  input  logic [c_NIB_W-1:0] core_tx_adpcm,
  output logic               busy,
  output logic               err
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic w_grant_dec;
  logic w_grant_valid;
  logic w_idle;
  logic w_accept;
  logic w_kick;
  logic w_finish;
  logic w_waiting;
  logic w_tmo_hit;

  adpcm_sched_arb #(
    .DEC_BURST (DEC_BURST)
  ) u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .enc_valid   (enc_valid),
    .dec_valid   (dec_valid),
    .accept      (w_accept),
    .grant_dec   (w_grant_dec),
    .grant_valid (w_grant_valid)
  );

  assign w_waiting = (r_state == c_WAIT_LO) || (r_state == c_WAIT_HI);

`ifdef ADPCM_SCHED_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic       r_err;

  assign w_tmo_hit = w_waiting && (r_tmo == 8'(TIMEOUT - 1));
  assign err       = r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else if (!enable) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_waiting ? r_tmo + 8'd1 : 8'd0;
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_tmo_hit && !w_finish) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  logic [7:0] w_unused_timeout;

  assign w_unused_timeout = 8'(TIMEOUT);
  assign w_tmo_hit        = 1'b0;
  assign err              = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_IDLE;
    end else if (!enable) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (w_accept) w_state_nxt = c_SETUP;
      c_SETUP:   w_state_nxt = c_WAIT_LO;
      c_WAIT_LO: begin
        if (w_tmo_hit) w_state_nxt = c_IDLE;
        else if (!core_ack) w_state_nxt = c_WAIT_HI;
      end
      c_WAIT_HI: begin
        if (core_ack || w_tmo_hit) w_state_nxt = c_IDLE;
      end
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // ---------------- outputs / strobes ----------------
  // rstn gates ready so the combinational outputs also read 0 during reset
  always_comb begin
    w_idle    = (r_state == c_IDLE) && enable && rstn;
    enc_ready = w_idle & w_grant_valid & ~w_grant_dec;
    dec_ready = w_idle & w_grant_valid & w_grant_dec;
    w_accept  = (enc_ready & enc_valid) | (dec_ready & dec_valid);
    w_kick    = enable && (r_state == c_SETUP);
    w_finish  = enable && (r_state == c_WAIT_HI) && core_ack;
    busy      = (r_state != c_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_req      <= 1'b0;
      core_sel_rx   <= c_SEL_ENC;
      core_rx_pcm   <= '0;
      core_rx_adpcm <= '0;
      enc_done      <= 1'b0;
      enc_adpcm     <= '0;
      dec_done      <= 1'b0;
      dec_pcm       <= '0;
    end else if (!enable) begin
      core_req      <= 1'b0;
      core_sel_rx   <= c_SEL_ENC;
      core_rx_pcm   <= '0;
      core_rx_adpcm <= '0;
      enc_done      <= 1'b0;
      enc_adpcm     <= '0;
      dec_done      <= 1'b0;
      dec_pcm       <= '0;
    end else begin
      enc_done <= 1'b0;
      dec_done <= 1'b0;
      if (w_accept) begin
        core_sel_rx   <= w_grant_dec ? c_SEL_DEC : c_SEL_ENC;
        core_rx_pcm   <= w_grant_dec ? '0 : enc_pcm;
        core_rx_adpcm <= w_grant_dec ? dec_adpcm : '0;
      end
      // request flips one edge after sel/data settle on the core inputs
      if (w_kick) begin
        core_req <= ~core_req;
      end
      if (w_finish) begin
        if (core_sel_rx == c_SEL_DEC) begin
          dec_pcm  <= core_tx_pcm;
          dec_done <= 1'b1;
        end else begin
          enc_adpcm <= core_tx_adpcm;
          enc_done  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adpcm_sched.sv
// ============================================================================
// tb_adpcm_sched : randomized self-checking bench with a transaction-level model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adpcm_sched;

  localparam int TB_BURST   = 2;
  localparam int TB_TIMEOUT = 31;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        enc_valid = 1'b0;
  logic [15:0] enc_pcm = '0;
  logic        dec_valid = 1'b0;
  logic [3:0]  dec_adpcm = '0;
  logic        enc_ready, enc_done, dec_ready, dec_done;
  logic [3:0]  enc_adpcm, core_rx_adpcm, core_tx_adpcm;
  logic [15:0] dec_pcm, core_rx_pcm, core_tx_pcm;
  logic        core_req, core_sel_rx, core_ack, busy, err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  adpcm_sched #(
    .DEC_BURST (TB_BURST),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .enc_valid     (enc_valid),
    .enc_pcm       (enc_pcm),
    .enc_ready     (enc_ready),
    .enc_done      (enc_done),
    .enc_adpcm     (enc_adpcm),
    .dec_valid     (dec_valid),
    .dec_adpcm     (dec_adpcm),
    .dec_ready     (dec_ready),
    .dec_done      (dec_done),
    .dec_pcm       (dec_pcm),
    .core_req      (core_req),
    .core_sel_rx   (core_sel_rx),
    .core_rx_pcm   (core_rx_pcm),
    .core_rx_adpcm (core_rx_adpcm),
    .core_ack      (core_ack),
    .core_tx_pcm   (core_tx_pcm),
    .core_tx_adpcm (core_tx_adpcm),
    .busy          (busy),
    .err           (err)
  );

  function automatic logic [3:0] f_enc(input logic [15:0] pcm);
    return pcm[3:0] ^ pcm[11:8] ^ 4'h6;
  endfunction

  function automatic logic [15:0] f_dec(input logic [3:0] nib);
    return {nib, ~nib, nib ^ 4'h3, nib};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Codec core: toggle request -> ack low for 7 cycles -> result with ack high
  logic        core_seen;
  logic        core_dead = 1'b0;
  int          core_cnt;
  logic        core_lat_sel;
  logic [15:0] core_lat_pcm;
  logic [3:0]  core_lat_nib;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_ack <= 1'b1; core_seen <= 1'b0; core_cnt <= 0;
      core_tx_pcm <= '0; core_tx_adpcm <= '0;
    end else if (!enable) begin
      core_ack <= 1'b1; core_seen <= 1'b0; core_cnt <= 0;
    end else if (core_ack && (core_req != core_seen)) begin
      core_seen <= core_req;
      if (!core_dead) begin
        core_ack      <= 1'b0;
        core_cnt      <= 6;
        core_lat_sel  <= core_sel_rx;
        core_lat_pcm  <= core_rx_pcm;
        core_lat_nib  <= core_rx_adpcm;
        core_tx_pcm   <= 16'($urandom);
        core_tx_adpcm <= 4'($urandom);
      end
    end else if (!core_ack) begin
      if (core_cnt == 0) begin
        core_ack <= 1'b1;
        if (core_lat_sel) core_tx_pcm <= f_dec(core_lat_nib);
        else core_tx_adpcm <= f_enc(core_lat_pcm);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Transaction-level reference: one job occupies the scheduler for 10 edges
  int          ecount = 0;
  int          free_at = 0;
  int          run = 0;
  bit          job_active = 0;
  bit          pend_dec;
  logic [15:0] pend_pcm;
  logic [3:0]  pend_nib;
  bit          exp_req = 0;
  logic [3:0]  exp_enc = '0;
  logic [15:0] exp_dec = '0;
  bit          was_disabled = 0;
  int          acc_q[$];
  bit          grants[$];

  task automatic model_reset();
    run = 0; job_active = 0; free_at = 0; exp_req = 0;
    exp_enc = '0; exp_dec = '0; was_disabled = 1;
  endtask

  task automatic check_regs();
    bit fin_enc, fin_dec, exp_busy;
    fin_enc  = job_active && (ecount == free_at) && !pend_dec;
    fin_dec  = job_active && (ecount == free_at) && pend_dec;
    exp_busy = job_active && (ecount < free_at);
    if (fin_enc) exp_enc = f_enc(pend_pcm);
    if (fin_dec) exp_dec = f_dec(pend_nib);
    chk_eq("enc_done", enc_done, fin_enc);
    chk_eq("dec_done", dec_done, fin_dec);
    chk_eq("enc_adpcm", enc_adpcm, exp_enc);
    chk_eq("dec_pcm", dec_pcm, exp_dec);
    chk_eq("busy", busy, exp_busy);
    chk_eq("err", err, 0);
    if (job_active && (ecount == free_at - 10)) begin
      chk_eq("core_sel_rx", core_sel_rx, pend_dec);
      chk_eq("core_rx_pcm", core_rx_pcm, pend_dec ? 16'h0 : pend_pcm);
      chk_eq("core_rx_adpcm", core_rx_adpcm, pend_dec ? pend_nib : 4'h0);
      chk_eq("core_req_setup", core_req, exp_req);
    end
    if (job_active && (ecount == free_at - 9)) begin
      exp_req = ~exp_req;
      chk_eq("core_req_toggle", core_req, exp_req);
    end
    if (was_disabled) begin
      chk_eq("clr_core_req", core_req, 0);
      chk_eq("clr_core_sel", core_sel_rx, 0);
      chk_eq("clr_core_pcm", core_rx_pcm, 0);
      chk_eq("clr_core_nib", core_rx_adpcm, 0);
      was_disabled = 0;
    end
    if (ecount >= free_at) job_active = 0;
  endtask

  task automatic step(input bit en, input bit ev, input logic [15:0] ep,
                      input bit dv, input logic [3:0] da);
    bit idle, g_dec, acc;
    @(negedge clk);
    check_regs();
    enable = en; enc_valid = ev; enc_pcm = ep; dec_valid = dv; dec_adpcm = da;
    #1;
    idle  = en && (ecount >= free_at);
    g_dec = dv && (!ev || (run < TB_BURST));
    acc   = idle && (ev || dv);
    chk_eq("enc_ready", enc_ready, idle && ev && !g_dec);
    chk_eq("dec_ready", dec_ready, idle && dv && g_dec);
    if ((enc_ready && ev) || (dec_ready && dv)) grants.push_back(dec_ready);
    @(posedge clk);
    ecount++;
    if (!en) begin
      model_reset();
    end else if (acc) begin
      run        = g_dec ? ((run < TB_BURST) ? run + 1 : run) : 0;
      free_at    = ecount + 10;
      job_active = 1;
      pend_dec   = g_dec;
      pend_pcm   = ep;
      pend_nib   = da;
      acc_q.push_back(ecount);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 16'h0, 0, 4'h0);
  endtask

  initial begin
    int          n;
    bit          saw_done;
    bit          exp_g[6];
    logic [15:0] rp;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_core_req", core_req, 0);
    chk_eq("rst_enc_ready", enc_ready, 0);
    chk_eq("rst_dec_pcm", dec_pcm, 0);
    chk_eq("rst_err", err, 0);
    rstn = 1'b1;
    model_reset();

    // encode only
    step(1, 1, 16'sd1000, 0, 4'h0);
    idle_steps(12);

    // decode back-to-back with dec_valid held
    acc_q.delete();
    step(1, 0, 16'h0, 1, 4'h7);
    for (int i = 0; i < 20; i++) step(1, 0, 16'h0, 1, 4'hF);
    idle_steps(11);
    chk_eq("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) chk_eq("b2b_gap", acc_q[1] - acc_q[0], 11);

    // contention with burst credit 2
    step(0, 0, 16'h0, 0, 4'h0);
    grants.delete();
    for (int i = 0; i < 66; i++) step(1, 1, 16'($urandom), 1, 4'($urandom));
    idle_steps(11);
    exp_g = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    chk_eq("grant_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk_eq($sformatf("grant_%0d", i), grants[i], exp_g[i]);

    // randomized traffic with occasional enable drops
    for (int i = 0; i < 600; i++)
      step(($urandom % 64) != 0, ($urandom % 3) == 0, 16'($urandom),
           ($urandom % 3) != 0, 4'($urandom));
    idle_steps(11);

    // drop enable in WAIT_HI, then a fresh job
    step(1, 1, 16'h1234, 0, 4'h0);
    idle_steps(5);
    step(0, 0, 16'h0, 0, 4'h0);
    step(1, 0, 16'h0, 1, 4'h9);
    idle_steps(11);

    // async reset while in SETUP
    step(1, 1, 16'h7ABC, 0, 4'h0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_core_pcm", core_rx_pcm, 0);
    chk_eq("arst_enc_ready", enc_ready, 0);
    chk_eq("arst_core_req", core_req, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1; enc_valid = 1'b0;
    model_reset();
    step(1, 1, 16'hFFFF, 0, 4'h0);
    idle_steps(11);

`ifdef ADPCM_SCHED_TIMEOUT_EN
    // core never answers: scheduler gives up and flags err
    core_dead = 1'b1;
    @(negedge clk);
    enc_valid = 1'b1; enc_pcm = 16'h0042;
    #1 chk_eq("tmo_ready", enc_ready, 1);
    @(posedge clk);
    @(negedge clk);
    enc_valid = 1'b0;
    n = 0; saw_done = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (enc_done || dec_done) saw_done = 1;
    end
    chk_eq("tmo_cycles", n, TB_TIMEOUT + 1);
    chk_eq("tmo_err", err, 1);
    chk_eq("tmo_no_done", saw_done, 0);
    core_dead = 1'b0;
    rp = 16'h0ABC;
    enc_valid = 1'b1; enc_pcm = rp;
    @(posedge clk);
    @(negedge clk);
    enc_valid = 1'b0;
    chk_eq("tmo_err_clr", err, 0);
    n = 0;
    while (!enc_done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk_eq("tmo_recover_done", enc_done, 1);
    chk_eq("tmo_recover_data", enc_adpcm, f_enc(rp));
    enable = 1'b0;
    @(posedge clk);
    model_reset();
    idle_steps(3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
